// File: rtl/link_sink_queue.sv
// Two-pointer FIFO sink queue: registered storage, no flow-through and no pipe bypass.
// Full and empty are told apart by a maybe_full flag when the pointers coincide.
module link_sink_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_enq_valid,
    output logic                     io_enq_ready,
    input  logic [WIDTH-1:0]         io_enq_bits,
    output logic                     io_deq_valid,
    input  logic                     io_deq_ready,
    output logic [WIDTH-1:0]         io_deq_bits,
    output logic [$clog2(DEPTH):0]   io_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    enq_ptr;
    logic [PW-1:0]    deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] head;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match && !maybe_full;
    assign full      = ptr_match && maybe_full;

    assign io_enq_ready = !full;
    assign io_deq_valid = !empty;

    assign enq_fire = io_enq_valid && io_enq_ready;
    assign deq_fire = io_deq_valid && io_deq_ready;

    // Each entry has its own write enable decoded from enq_ptr; storage is left unreset.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        always_ff @(posedge clock) begin
            if (enq_fire && (enq_ptr == PW'(e))) begin
                ram[e] <= io_enq_bits;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (enq_fire) begin
                enq_ptr <= enq_ptr + PW'(1);
            end
            if (deq_fire) begin
                deq_ptr <= deq_ptr + PW'(1);
            end
            if (enq_fire != deq_fire) begin
                maybe_full <= enq_fire;
            end
        end
    end

    // Gate the head so stale storage never leaks out while empty.
    assign head        = ram[deq_ptr];
    assign io_deq_bits = empty ? '0 : head;

    assign io_count = full ? CW'(DEPTH) : {1'b0, enq_ptr - deq_ptr};

endmodule

// File: tb/tb_link_sink_queue.sv
// Randomized and directed bench for link_sink_queue against a queue-based reference model.
module tb_link_sink_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clock;
    logic             reset;
    logic             io_enq_valid;
    logic             io_enq_ready;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_deq_valid;
    logic             io_deq_ready;
    logic [WIDTH-1:0] io_deq_bits;
    logic [$clog2(DEPTH):0] io_count;

    link_sink_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_ready (io_enq_ready),
        .io_enq_bits  (io_enq_bits),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_count     (io_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] model_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic ev, input logic [WIDTH-1:0] eb, input logic dr,
                        input logic rst, input bit do_check);
        logic enq_ok;
        logic deq_ok;
        io_enq_valid = ev;
        io_enq_bits  = eb;
        io_deq_ready = dr;
        reset        = rst;
        #1;
        if (do_check) begin
            chk("count", 32'(io_count), 32'(model_q.size()));
            chk("enq_ready", 32'(io_enq_ready), 32'(model_q.size() < DEPTH));
            chk("deq_valid", 32'(io_deq_valid), 32'(model_q.size() > 0));
            chk("deq_bits", io_deq_bits, (model_q.size() > 0) ? model_q[0] : '0);
        end
        enq_ok = ev && (model_q.size() < DEPTH);
        deq_ok = dr && (model_q.size() > 0);
        @(posedge clock);
        if (rst) begin
            model_q.delete();
        end else begin
            if (deq_ok) void'(model_q.pop_front());
            if (enq_ok) model_q.push_back(eb);
        end
        @(negedge clock);
    endtask

    initial begin
        io_enq_valid = 1'b0;
        io_enq_bits  = '0;
        io_deq_ready = 1'b0;
        reset        = 1'b1;

        // Reset, then idle
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Fill to full with the consumer stalled; a fifth beat must bounce
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Drain from full
        for (int i = 0; i < 5; i++) step(1'b0, 32'hDEAD, 1'b1, 1'b0, 1'b1);

        // Full with both sides asking: nothing enters, occupancy drops to DEPTH-1
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i + 8'hC0), 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hBAD, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // One held entry, simultaneous enq/deq
        step(1'b1, 32'h01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hAA, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Empty with valid input: no flow-through, ten-beat stream across wraps
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Reset mid-operation discards contents and the beat offered during reset
        for (int i = 0; i < 3; i++) step(1'b1, 32'(8'hE0 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h77, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 60), $urandom(),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
